// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU op encodings,
// FSM state encoding and a small grant-mask helper.
package alu_share_arbiter_pkg;

    // ALU Control encodings, identical to the ones the ALU decodes
    localparam logic [2:0] ALU_AND      = 3'b000;
    localparam logic [2:0] ALU_OR       = 3'b001;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b110;
    localparam logic [2:0] ALU_SLT      = 3'b111;

    localparam int CTRL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot mask selecting requester idx
    function automatic logic [1:0] req_mask(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester always wins;
// on contention the requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick the winner from the current requests and the last grant
    always_comb begin
        // NOTE: gnt gets a default before any conditional logic so no path leaves it unassigned, which would infer a latch.
        gnt = 2'b00;
        if (req[0] && (!req[1] || last)) begin
            gnt = 2'b01;
        end else if (req[1] && (!req[0] || !last)) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one external combinational ALU between two requesters. A winning
// request is latched into the ALU operand registers, evaluated for one
// cycle, and the captured result is held on the winner's response channel
// until it is taken.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [2*CTRL_W-1:0]  req_ctrl,
    input  logic [2*WIDTH-1:0]   req_a,
    input  logic [2*WIDTH-1:0]   req_b,
    output logic [1:0]           rsp_valid,
    input  logic [1:0]           rsp_ready,
    output logic [WIDTH-1:0]     rsp_result,
    output logic                 rsp_zero,
    output logic [CTRL_W-1:0]    alu_control,
    output logic [WIDTH-1:0]     alu_srca,
    output logic [WIDTH-1:0]     alu_srcb,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic                 alu_zero
);

    state_t     state;
    logic       last_grant;   // index of the most recently granted requester
    logic       owner;        // requester whose op is in flight
    logic [1:0] gnt;
    logic       win;

    rr_arb2 u_arb (
        .req  (req_valid),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign win       = gnt[1];
    // Requests are only accepted while no op is in flight
    assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;

    // Sequencing FSM with operand, result and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            rsp_valid   <= 2'b00;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            alu_control <= '0;
            alu_srca    <= '0;
            alu_srcb    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        alu_control <= win ? req_ctrl[2*CTRL_W-1:CTRL_W] : req_ctrl[CTRL_W-1:0];
                        alu_srca    <= win ? req_a[2*WIDTH-1:WIDTH]      : req_a[WIDTH-1:0];
                        alu_srcb    <= win ? req_b[2*WIDTH-1:WIDTH]      : req_b[WIDTH-1:0];
                        owner       <= win;
                        last_grant  <= win;
                        state       <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for a full cycle; sample the ALU
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_valid  <= req_mask(owner);
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_valid[owner] && rsp_ready[owner]) begin
                        rsp_valid <= 2'b00;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a behavioural ALU sits on the
// alu_* side, a driver feeds per-requester op queues, and a monitor checks
// every response against a per-requester scoreboard.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int WIDTH = 8;

    typedef struct {
        logic [2:0] ctrl;
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    typedef struct {
        logic [7:0] res;
        logic       z;
        int         cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [5:0]        req_ctrl;
    logic [15:0]       req_a;
    logic [15:0]       req_b;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [7:0]        rsp_result;
    logic              rsp_zero;
    logic [2:0]        alu_control;
    logic [7:0]        alu_srca;
    logic [7:0]        alu_srcb;
    logic [7:0]        alu_result;
    logic              alu_zero;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    op_t  pend0[$];
    op_t  pend1[$];
    exp_t sb0[$];
    exp_t sb1[$];
    int   glog[$];

    int   mode = 0;    // 0: rsp_ready high, 1: random, 2: low
    bit   gap  = 1'b0; // randomly drop req_valid without a handshake

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ctrl    (req_ctrl),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .alu_control (alu_control),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: combinational, undefined codes yield 0
    function automatic logic [8:0] alu_fn(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (c)
            ALU_ADD:      r = a + b;
            ALU_SUBTRACT: r = a - b;
            ALU_AND:      r = a & b;
            ALU_OR:       r = a | b;
            ALU_SLT:      r = ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            default:      r = 8'd0;
        endcase
        return {(r == 8'd0), r};
    endfunction

    assign {alu_zero, alu_result} = alu_fn(alu_control, alu_srca, alu_srcb);

    // Reference: what the requester should get back for an op, in plain integers
    function automatic exp_t ref_op(input op_t op);
        exp_t e;
        int ia, ib, sa, sb, r;
        ia = int'(op.a);
        ib = int'(op.b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        if (op.ctrl == ALU_ADD)           r = (ia + ib) % 256;
        else if (op.ctrl == ALU_SUBTRACT) r = (ia - ib + 256) % 256;
        else if (op.ctrl == ALU_AND)      r = int'(op.a & op.b);
        else if (op.ctrl == ALU_OR)       r = int'(op.a | op.b);
        else if (op.ctrl == ALU_SLT)      r = (sa < sb) ? 1 : 0;
        else                              r = 0;
        e.res = 8'(r);
        e.z   = (r == 0);
        e.cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Driver: presents queue fronts, records accepted ops into the scoreboard
    initial begin
        op_t  cur0, cur1;
        exp_t e;
        logic [1:0] acc;
        cur0 = '{3'd0, 8'd0, 8'd0};
        cur1 = '{3'd0, 8'd0, 8'd0};
        req_valid = 2'b00;
        req_ctrl  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b11;
        forever begin
            @(negedge clk);
            acc = 2'b00;
            if (!rst_n) begin
                sb0.delete();
                sb1.delete();
            end else begin
                acc = req_valid & req_ready;
                if (acc[0]) begin
                    e = ref_op(cur0); e.cyc = cyc; sb0.push_back(e); glog.push_back(0);
                end
                if (acc[1]) begin
                    e = ref_op(cur1); e.cyc = cyc; sb1.push_back(e); glog.push_back(1);
                end
            end
            @(posedge clk);
            #1;
            if (acc[0] && pend0.size() > 0) void'(pend0.pop_front());
            if (acc[1] && pend1.size() > 0) void'(pend1.pop_front());
            if (pend0.size() > 0 && !(gap && $urandom_range(0, 3) == 0)) begin
                cur0 = pend0[0]; req_valid[0] = 1'b1;
            end else begin
                req_valid[0] = 1'b0;
            end
            if (pend1.size() > 0 && !(gap && $urandom_range(0, 3) == 0)) begin
                cur1 = pend1[0]; req_valid[1] = 1'b1;
            end else begin
                req_valid[1] = 1'b0;
            end
            req_ctrl = {cur1.ctrl, cur0.ctrl};
            req_a    = {cur1.a, cur0.a};
            req_b    = {cur1.b, cur0.b};
            case (mode)
                0:       rsp_ready = 2'b11;
                1:       rsp_ready = 2'($urandom_range(0, 3));
                default: rsp_ready = 2'b00;
            endcase
        end
    end

    // Monitor: latency, hold stability and result checks on each response
    initial begin
        bit         seen[2];
        bit         held[2];
        logic [7:0] hr[2];
        logic       hz[2];
        exp_t       e;
        bit         empty;
        seen = '{0, 0};
        held = '{0, 0};
        hr   = '{8'd0, 8'd0};
        hz   = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = '{0, 0};
                held = '{0, 0};
            end else begin
                if (rsp_valid != 2'b00)
                    check("rsp_onehot_and_no_req_ready", {30'd0, (rsp_valid == 2'b11), (req_ready != 2'b00)}, 32'd0);
                for (int i = 0; i < 2; i++) begin
                    if (held[i])
                        check($sformatf("rsp%0d_held_stable", i), {rsp_valid[i], rsp_zero, rsp_result}, {1'b1, hz[i], hr[i]});
                    if (rsp_valid[i]) begin
                        empty = (i == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
                        if (empty) begin
                            check($sformatf("rsp%0d_spurious", i), 32'(rsp_valid), 32'd0);
                        end else begin
                            e = (i == 0) ? sb0[0] : sb1[0];
                            if (!seen[i]) begin
                                check($sformatf("rsp%0d_latency", i), cyc, e.cyc + 2);
                                seen[i] = 1'b1;
                            end
                            if (rsp_ready[i]) begin
                                if (i == 0) void'(sb0.pop_front());
                                else        void'(sb1.pop_front());
                                check($sformatf("rsp%0d_result_zero", i), {rsp_zero, rsp_result}, {e.z, e.res});
                                seen[i] = 1'b0;
                            end
                        end
                    end
                    held[i] = rsp_valid[i] && !rsp_ready[i];
                    hr[i]   = rsp_result;
                    hz[i]   = rsp_zero;
                end
            end
        end
    end

    task automatic wait_drain(input string name, input int budget);
        bit ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (pend0.size() == 0 && pend1.size() == 0 && sb0.size() == 0 && sb1.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check({"drain_", name}, 32'(ok), 32'd1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_rsp"}, {rsp_valid, rsp_zero, rsp_result}, 32'd0);
        check({name, "_alu"}, {alu_control, alu_srca, alu_srcb}, 32'd0);
    endtask

    initial begin
        int prev_last;
        int n;
        bit ok;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // Contention in the first cycle after reset: req0 first
        @(negedge clk);
        rst_n = 1'b1;
        pend0.push_back('{ALU_SUBTRACT, 8'd123, 8'd123});
        pend1.push_back('{ALU_OR, 8'h0F, 8'hF0});
        wait_drain("contention", 40);
        check("contention_count", glog.size(), 2);
        if (glog.size() == 2) check("contention_order", {glog[0][7:0], glog[1][7:0]}, 16'h0001);

        // Single requester, alu_* retained afterwards
        glog.delete();
        pend0.push_back('{ALU_ADD, 8'd100, 8'd27});
        wait_drain("add", 40);
        check("add_grant_req0", glog.size() == 1 ? glog[0] : -1, 0);
        check("alu_retained_idle", {alu_control, alu_srca, alu_srcb}, {ALU_ADD, 8'd100, 8'd27});

        // Backpressure for 5 cycles, other requester waiting
        mode = 2;
        pend1.push_back('{ALU_ADD, 8'd1, 8'd2});
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid[1]) begin ok = 1'b1; break; end
        end
        check("bp_rsp_arrives", 32'(ok), 32'd1);
        pend0.push_back('{ALU_OR, 8'h30, 8'h03});
        repeat (4) begin
            @(negedge clk);
            check("bp_req_ready_low", {req_ready, rsp_valid}, {2'b00, 2'b10});
        end
        mode = 0;
        @(negedge clk);
        check("bp_still_valid_6th", 32'(rsp_valid), 32'd2);
        @(negedge clk);
        check("bp_released", 32'(rsp_valid), 32'd0);
        wait_drain("backpressure", 40);

        // SLT and AND boundary cases on requester 1
        pend1.push_back('{ALU_SLT, 8'd3, 8'd5});
        pend1.push_back('{ALU_SLT, 8'd5, 8'd3});
        pend1.push_back('{ALU_AND, 8'hAA, 8'h55});
        pend1.push_back('{ALU_SLT, 8'hFF, 8'h01});
        wait_drain("slt_and", 60);

        // Continuous contention: strict alternation
        prev_last = glog.size() > 0 ? glog[glog.size() - 1] : 1;
        glog.delete();
        for (int k = 0; k < 4; k++) begin
            pend0.push_back('{ALU_ADD, 8'(k), 8'd10});
            pend1.push_back('{ALU_SUBTRACT, 8'd50, 8'(k)});
        end
        wait_drain("alternate", 80);
        check("alternate_count", glog.size(), 8);
        for (int k = 0; k < glog.size(); k++)
            check($sformatf("alternate_grant%0d", k), glog[k], (k % 2 == 0) ? 1 - prev_last : prev_last);

        // Randomised traffic with backpressure and dropped valids
        mode = 1;
        gap  = 1'b1;
        for (int k = 0; k < 80; k++) begin
            op_t op;
            op.ctrl = 3'($urandom_range(0, 7));
            op.a    = 8'($urandom_range(0, 255));
            op.b    = ($urandom_range(0, 3) == 0) ? op.a : 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 0) pend0.push_back(op);
            else                           pend1.push_back(op);
        end
        wait_drain("random", 3000);
        mode = 0;
        gap  = 1'b0;

        // Reset during EXEC discards the op
        n = glog.size();
        pend0.push_back('{ALU_ADD, 8'd5, 8'd6});
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (glog.size() > n) begin ok = 1'b1; break; end
        end
        check("rst_op_accepted", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("midreset_no_rsp", 32'(rsp_valid), 32'd0);
        end
        glog.delete();
        pend0.push_back('{ALU_OR, 8'h01, 8'h02});
        pend1.push_back('{ALU_AND, 8'h0F, 8'h0C});
        wait_drain("post_reset", 40);
        check("post_reset_first_req0", glog.size() > 0 ? glog[0] : -1, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    // Absolute bound on the run
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
